// File: rtl/irq_ctrl.sv
// Eight-source interrupt controller for the 65C02 IRQ line.
// Per-source sync, edge/level latch, mask, priority vector, registered bus reads.
module irq_ctrl #(
   parameter int          NSRC = 8,
   parameter logic [15:0] BASE = 16'h8810
) (
   input  logic            clk,
   input  logic            resb,
   input  logic [15:0]     ab,
   input  logic            we,
   input  logic [7:0]      di,
   output logic [7:0]      dout,
   output logic            sel,
   input  logic [NSRC-1:0] src,
   output logic            irq
);

   localparam logic [7:0] VMASK = 8'((1 << NSRC) - 1);

   logic [7:0] src_w;
   logic [7:0] s1, s2, s3;
   logic [7:0] pend, mask, edg;
   logic [7:0] en, w1c, pend_nx, vec, rmux;
   logic [2:0] off, idx;
   logic       hit, wr, rd;

   assign hit = (ab[15:3] == BASE[15:3]);
   assign off = ab[2:0];
   assign wr  = hit & we;
   assign rd  = hit & ~we;
   assign en  = pend & mask;

   always_comb begin
      src_w = '0;
      src_w[NSRC-1:0] = src;
   end

   assign w1c = (wr && off == 3'd1) ? (di & VMASK) : 8'h00;

   // Edge bits: hold, clear on W1C, set wins; level bits track s2.
   assign pend_nx = ((((pend & ~w1c) | (s2 & ~s3)) & edg)
                   | (s2 & ~edg)) & VMASK;

   always_comb begin
      idx = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (en[i]) idx = 3'(i);
   end

   assign vec = (|en) ? {1'b1, 4'b0000, idx} : 8'h00;

   always_comb begin
      rmux = 8'h00;
      unique case (off)
         3'd0:    rmux = s2;
         3'd1:    rmux = pend;
         3'd2:    rmux = mask;
         3'd3:    rmux = edg;
         3'd4:    rmux = vec;
         default: rmux = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge resb) begin
      if (!resb) begin
         s1   <= '0;
         s2   <= '0;
         s3   <= '0;
         pend <= '0;
         mask <= '0;
         edg  <= '0;
         irq  <= 1'b0;
         sel  <= 1'b0;
         dout <= '0;
      end else begin
         s1   <= src_w & VMASK;
         s2   <= s1;
         s3   <= s2;
         pend <= pend_nx;
         irq  <= |en;
         sel  <= rd;
         if (wr && off == 3'd2) mask <= di & VMASK;
         if (wr && off == 3'd3) edg  <= di & VMASK;
         if (rd) dout <= rmux;
      end
   end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller between the system's peripherals (ACIA, VIA, spare pins) and the 65C02 `IRQ` input. It synchronises up to eight interrupt sources, latches them per source in edge or level mode, masks them, and drives one registered active-high IRQ to the CPU. Registers sit in an 8-byte window of the I/O page. Read data is registered so it lines up with the one-cycle-delayed read mux already used for RAM, ROM, ACIA and VIA.

## Interface
- `NSRC`, 8: number of interrupt sources, legal range 1..8.
- `BASE`, 16'h8810: window base address; must be 8-byte aligned.

- `clk`  in  1  system clock (CPU clock).
- `resb`  in  1  asynchronous active-low reset.
- `ab`  in  16  CPU address bus.
- `we`  in  1  CPU write enable (1 = write).
- `di`  in  8  CPU write data.
- `do`  out  8  registered read data.
- `sel`  out  1  registered "read hit"; the top-level read mux uses it to select `do`.
- `src`  in  NSRC  interrupt requests, active high, asynchronous (invert ACIA/VIA `IRQn` outside).
- `irq`  out  1  interrupt request to CPU, active high, registered.

## Operation
- Decode: `hit = (ab[15:3] == BASE[15:3])`; `off = ab[2:0]`.
- Each source has a 2-flop synchroniser (s1→s2) plus a history flop s3.
- Registers, all reset to 0:
  - off 0 STATUS (R): synchronised raw levels s2. Writes are ignored.
  - off 1 PENDING (R, W1C): latched requests.
  - off 2 MASK (R/W): 1 = enabled.
  - off 3 EDGE (R/W): 1 = rising-edge mode, 0 = level mode.
  - off 4 VECTOR (R): `{any, 4'b0, idx[2:0]}`. `any = |(PENDING & MASK)`. `idx` = lowest-numbered set bit of `PENDING & MASK` (bit 0 has highest priority). Reads 8'h00 when `any` = 0.
  - off 5–7: read 8'h00; writes are ignored.
- Bits at or above NSRC read 0 in every register and cannot be written.
- Pending update per bit i, each clock:
  - Edge mode: set on `s2 & ~s3`; cleared by a write of 1 to PENDING bit i. A set and a clear in the same cycle resolve to set.
  - Level mode: `PENDING[i] <= s2`. W1C has no effect.
- Pending ignores MASK; masking only gates `irq` and VECTOR.
- Mode change: 1→0 makes pending follow s2 from the next edge. 0→1 keeps the current pending value; after that only new rising edges set it.
- `irq <= |(PENDING & MASK)` (next-state values not used; registered from current registers).
- Reads have no side effects.

## Timing
- Write: register updates on the rising edge where `hit & we`, using `di`.
- Read: on each edge, `sel <= hit & ~we`. When `hit & ~we`, `do <=` register[off] (current value), otherwise `do` holds. Data is valid the cycle after the address, matching the synchronous RAM/ROM.
- Source latency: if `src[i]` rises before edge k, then s1=1 after k, s2 after k+1, PENDING[i] after k+2, and `irq` after k+3 (when masked in).
- MASK write at edge k changes `irq` at edge k+1. A W1C that clears the last enabled pending bit at edge k drops `irq` at edge k+1.
- A read of PENDING/VECTOR in the same cycle as an update returns the pre-update value.
- Asynchronous reset mid-operation clears all flops immediately: `do`=0, `sel`=0, `irq`=0. Sources high at reset release are captured after 3 edges (level) or treated as new edges (edge mode, since s3=0).

## Test plan
- Reset: hold `resb`=0 with `src`=8'hFF. Require `irq`=0, `do`=0, `sel`=0. Release, read MASK/EDGE/PENDING → 00/00/FF (level mode).
- Edge latch and clear: EDGE=8'h04, MASK=8'h04, pulse `src[2]` for 1 cycle. Require `irq`=1 three edges after the pulse and VECTOR=8'h82. Write PENDING=8'h04 → `irq`=0 next edge.
- Priority: level mode, MASK=8'hFF, `src`=8'h28 → VECTOR=8'h83. Drop `src[3]` → after 3 edges VECTOR=8'h85.
- Set/clear collision: edge mode on bit 0, rising edge detected in the same cycle as a W1C of bit 0 → PENDING[0] remains 1.
- Masking: `src[7]` high in level mode with MASK=0 → `irq`=0, PENDING=8'h80. Write MASK=8'h80 → `irq`=1 one edge later.
- Bus: write to off 0 and 5–7 is ignored. A read at BASE+7 gives `sel`=1 and `do`=00. An access at BASE+8 gives `sel`=0 and `do` unchanged.
